// File: rtl/fft_pkg.sv
// Shared FFT package: default sizes plus clog2 and bit_reverse helpers.
// Used by the reorder buffer and reusable by the FftTop benches.
package fft_pkg;

  localparam int unsigned FFT_N     = 1024;
  localparam int unsigned FFT_WIDTH = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Reverse the low log_n bits of value; upper bits of the result are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int unsigned log_n);
    logic [31:0]  r;
    int unsigned  src;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < log_n) begin
        src          = log_n - 1 - i;
        r[i[4:0]]    = value[src[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: clock; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out
// (registered, valid the cycle after rd_addr is presented). No reset on the array.
module fft_sdp_ram #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer behind the R2^2SDF FFT.
// Ping-pong RAM (2 banks x N words); each completed frame is streamed out as a
// contiguous N-cycle burst, bin 0 appearing two cycles after the frame's last input.
// Ports: clock, reset (async, active high); idata_en/idata_r/idata_i input stream
// in bit-reversed order; odata_en/odata_r/odata_i registered natural-order output.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
);

  localparam int unsigned      LOG_N    = clog2(N);
  localparam int unsigned      ADDR_W   = LOG_N + 1;
  localparam int unsigned      DATA_W   = 2 * WIDTH;
  localparam logic [LOG_N-1:0] CNT_LAST = LOG_N'(N - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_READ = 1'b1;

  logic [LOG_N-1:0]  wcnt_q;
  logic              wbank_q;
  logic [1:0]        full_q;
  logic              state_q, state_d;
  logic              rbank_q, rbank_d;
  logic [LOG_N-1:0]  rcnt_q, rcnt_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              frame_done_c;
  logic              read_last_c;

  assign frame_done_c = idata_en && (wcnt_q == CNT_LAST);
  assign read_last_c  = (state_q == ST_READ) && (rcnt_q == CNT_LAST);
  assign wr_addr_c    = {wbank_q, LOG_N'(bit_reverse(32'(wcnt_q), LOG_N))};

  // The RAM registers the read data, so it is fed the next-cycle address: data for
  // {rbank,rcnt} is then available while the FSM sits on that count.
  assign rd_addr_c    = {rbank_d, rcnt_d};

  fft_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (idata_en),
    .wr_addr (wr_addr_c),
    .wr_data ({idata_r, idata_i}),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // Write counter and bank; wraps and swaps bank on the last sample of a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
    end else if (idata_en) begin
      wcnt_q <= wcnt_q + LOG_N'(1);
      if (wcnt_q == CNT_LAST) begin
        wbank_q <= ~wbank_q;
      end
    end
  end

  // Bank-full flags; a set and a clear in the same cycle always hit different banks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
    end else begin
      if (frame_done_c) begin
        full_q[wbank_q] <= 1'b1;
      end
      if (read_last_c) begin
        full_q[rbank_q] <= 1'b0;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Read FSM next state. The other bank may complete in the very cycle the current
  // readout ends, before its full flag is visible, so frame_done_c is also checked.
  always_comb begin
    state_d = state_q;
    rbank_d = rbank_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_done_c) begin
          state_d = ST_READ;
          rbank_d = wbank_q;
          rcnt_d  = '0;
        end
      end
      ST_READ: begin
        rcnt_d = rcnt_q + LOG_N'(1);
        if (rcnt_q == CNT_LAST) begin
          rcnt_d = '0;
          if (full_q[~rbank_q] || (frame_done_c && (wbank_q != rbank_q))) begin
            rbank_d = ~rbank_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register; data forced to zero outside bursts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      odata_en   <= 1'b0;
      odata_r    <= '0;
      odata_i    <= '0;
    end else begin
      rd_valid_q <= (state_d == ST_READ);
      odata_en   <= rd_valid_q;
      odata_r    <= rd_valid_q ? rd_data[DATA_W-1:WIDTH] : '0;
      odata_i    <= rd_valid_q ? rd_data[WIDTH-1:0]      : '0;
    end
  end

endmodule
